// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Copies LEN words from a source region to a destination region of a single
//   synchronous single-port memory, one word every three cycles
//   (READ -> CAPTURE -> WRITE), in ascending address order.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               request pulse, sampled only in IDLE
//   src_addr, dst_addr  first source / destination word address
//   len                 word count, 0..MEM_SIZE
//   busy                high while the copy is running (READ/CAPTURE/WRITE)
//   done                one-cycle pulse on completion or on len=0
//   err                 one-cycle pulse when a request would run past MEM_SIZE
//   mem_wen, mem_addr, mem_din, mem_dout   memory master interface
module mem_copy_engine #(
    parameter int DATA_LENGTH = 8,
    parameter int MEM_SIZE    = 1024,
    localparam int ADDR_W     = $clog2(MEM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      src_addr,
    input  logic [ADDR_W-1:0]      dst_addr,
    input  logic [ADDR_W:0]        len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   mem_wen,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_LENGTH-1:0] mem_din,
    input  logic [DATA_LENGTH-1:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, FINISH} state_t;

    localparam logic [ADDR_W-1:0] ONE_A   = 1;
    localparam logic [ADDR_W:0]   ONE_L   = 1;
    localparam logic [ADDR_W+1:0] MEM_LIM = (ADDR_W+2)'(MEM_SIZE);

    state_t                 state, state_n;
    logic [ADDR_W-1:0]      src_q, src_n, dst_q, dst_n, idx, idx_n;
    logic [ADDR_W:0]        len_q, len_n;
    logic [DATA_LENGTH-1:0] data_q, data_n, din_n;
    logic [ADDR_W-1:0]      addr_n;
    logic                   busy_n, done_n, err_n, wen_n;
    logic [ADDR_W+1:0]      src_end, dst_end;

    // End addresses computed two bits wider than an address so that a request
    // running past the top of memory is caught instead of wrapping.
    assign src_end = {2'b00, src_addr} + {1'b0, len};
    assign dst_end = {2'b00, dst_addr} + {1'b0, len};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            data_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state    <= state_n;
            src_q    <= src_n;
            dst_q    <= dst_n;
            len_q    <= len_n;
            idx      <= idx_n;
            data_q   <= data_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
            mem_wen  <= wen_n;
            mem_addr <= addr_n;
            mem_din  <= din_n;
        end
    end

    // Outputs are registered, so each branch sets up what the memory must see
    // in the *next* state (e.g. the READ address is prepared on the way in).
    always_comb begin
        state_n = state;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        idx_n   = idx;
        data_n  = data_q;
        addr_n  = mem_addr;
        din_n   = mem_din;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    src_n = src_addr;
                    dst_n = dst_addr;
                    len_n = len;
                    idx_n = '0;
                    if (len == '0) begin
                        done_n = 1'b1;
                    end else if (src_end > MEM_LIM || dst_end > MEM_LIM) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = READ;
                        addr_n  = src_addr;
                    end
                end
            end
            READ: state_n = CAPTURE;
            CAPTURE: begin
                // Memory output is valid now; forward it straight to the
                // write-data register as well as holding it in data_q.
                data_n  = mem_dout;
                din_n   = mem_dout;
                addr_n  = dst_q + idx;
                state_n = WRITE;
            end
            WRITE: begin
                din_n = data_q;
                if ({1'b0, idx} == len_q - ONE_L) begin
                    state_n = FINISH;
                    done_n  = 1'b1;
                end else begin
                    idx_n   = idx + ONE_A;
                    addr_n  = src_q + idx + ONE_A;
                    state_n = READ;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        wen_n  = (state_n == WRITE);
        busy_n = (state_n == READ) || (state_n == CAPTURE) || (state_n == WRITE);
    end

endmodule
